// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Build option ARB_ROUND_ROBIN_EN (see arb_pick) selects the contention policy.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam logic [31:0] WORD_ADDR_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/arb_pick.sv
// Combinational owner selection between fetch and data requesters.
// ARB_ROUND_ROBIN_EN defined: alternate on contention; undefined: data side always wins.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic dm_req,
    input  logic last_grant,
    output logic grant,
    output logic any_req
);

    assign any_req = if_req | dm_req;

`ifdef ARB_ROUND_ROBIN_EN
    // On contention the requester that did not win last time gets the grant.
    always_comb begin
        grant = OWN_IF;
        if (if_req && dm_req) begin
            grant = (last_grant == OWN_IF) ? OWN_DM : OWN_IF;
        end else if (dm_req) begin
            grant = OWN_DM;
        end
    end
`else
    logic unused_last_grant;

    assign unused_last_grant = last_grant;
    assign grant             = dm_req ? OWN_DM : OWN_IF;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port memory, one transaction at a time.
// Contention policy is chosen by ARB_ROUND_ROBIN_EN inside arb_pick.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    output logic        if_err,

    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        dm_err,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    state_t      state;
    state_t      state_next;
    owner_t      owner;
    logic        last_grant;
    logic        grant;
    logic        any_req;
    logic [31:0] sel_addr;
    logic        sel_misaligned;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_we;
    logic        lat_err;

    arb_pick u_pick (
        .if_req     (if_req),
        .dm_req     (dm_req),
        .last_grant (last_grant),
        .grant      (grant),
        .any_req    (any_req)
    );

    assign sel_addr       = (grant == OWN_DM) ? dm_addr : if_addr;
    assign sel_misaligned = (sel_addr[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Misaligned requests skip the memory entirely and answer with an error.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        if_ready   = 1'b0;
        if_err     = 1'b0;
        dm_ready   = 1'b0;
        dm_err     = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = sel_misaligned ? RESP : BUSY;
                end
            end
            BUSY: begin
                mem_req   = 1'b1;
                mem_we    = lat_we;
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
                if (mem_ack) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
                if (owner == OWN_DM) begin
                    dm_ready = 1'b1;
                    dm_err   = lat_err;
                end else begin
                    if_ready = 1'b1;
                    if_err   = lat_err;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Grant-time latch of the owner's request, plus read-data capture on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= OWN_IF;
            last_grant <= OWN_IF;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            if_rdata   <= 32'h0;
            dm_rdata   <= 32'h0;
        end else begin
            if (state == IDLE && any_req) begin
                owner      <= owner_t'(grant);
                last_grant <= grant;
                lat_addr   <= sel_addr & WORD_ADDR_MASK;
                lat_wdata  <= (grant == OWN_DM) ? dm_wdata : 32'h0;
                lat_we     <= (grant == OWN_DM) && dm_we && !sel_misaligned;
                lat_err    <= sel_misaligned;
            end
            if (state == BUSY && mem_ack && !lat_we) begin
                if (owner == OWN_DM) begin
                    dm_rdata <= mem_rdata;
                end else begin
                    if_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; inputs change and outputs are checked on negedge.
// Expected contention order follows ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_err;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        dm_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int errors = 0;
    int checks = 0;

    logic        exp_dm [4];
    logic [31:0] exp_if_rdata;

    mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .if_err    (if_err),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .dm_err    (dm_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic dwe,
                                 input logic [31:0] daddr, input logic [31:0] dwdata);
        if_req   = ireq;
        if_addr  = iaddr;
        dm_req   = dreq;
        dm_we    = dwe;
        dm_addr  = daddr;
        dm_wdata = dwdata;
    endtask

    task automatic setMem(input logic ack, input logic [31:0] rdata);
        mem_ack   = ack;
        mem_rdata = rdata;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_dm[0] = 1'b1; exp_dm[1] = 1'b0; exp_dm[2] = 1'b1; exp_dm[3] = 1'b0;
`else
        exp_dm[0] = 1'b1; exp_dm[1] = 1'b1; exp_dm[2] = 1'b1; exp_dm[3] = 1'b1;
`endif
        exp_if_rdata = 32'h0;

        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        setMem(1'b0, 32'h0);
        #2;
        checkOutput("rst_mem_req", {31'h0, mem_req}, 32'h0);
        checkOutput("rst_mem_we", {31'h0, mem_we}, 32'h0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
        checkOutput("rst_readys", {28'h0, if_ready, if_err, dm_ready, dm_err}, 32'h0);
        checkOutput("rst_if_rdata", if_rdata, 32'h0);
        checkOutput("rst_dm_rdata", dm_rdata, 32'h0);

        // Contention: both requesters hold requests, memory acks immediately.
        step();
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 32'h300, 32'h0);
        setMem(1'b1, 32'h1111_2222);
        for (int t = 0; t < 4; t++) begin
            step();
            checkOutput("cont_mem_req", {31'h0, mem_req}, 32'h1);
            checkOutput("cont_mem_addr", mem_addr, exp_dm[t] ? 32'h300 : 32'h200);
            step();
            checkOutput("cont_dm_ready", {31'h0, dm_ready}, {31'h0, exp_dm[t]});
            checkOutput("cont_if_ready", {31'h0, if_ready}, {31'h0, !exp_dm[t]});
            if (!exp_dm[t]) exp_if_rdata = 32'h1111_2222;
            if (t == 3) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
            step();
            checkOutput("cont_idle_req", {31'h0, mem_req}, 32'h0);
        end
        checkOutput("cont_dm_rdata", dm_rdata, 32'h1111_2222);
        checkOutput("cont_if_rdata", if_rdata, exp_if_rdata);
        setMem(1'b0, 32'h0);

        // Single aligned fetch, ack in the first BUSY cycle.
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("f_n_ready", {31'h0, if_ready}, 32'h0);
        step();
        checkOutput("f_mem_req", {31'h0, mem_req}, 32'h1);
        checkOutput("f_mem_addr", mem_addr, 32'h40);
        checkOutput("f_mem_we", {31'h0, mem_we}, 32'h0);
        setMem(1'b1, 32'h2010_FFFF);
        step();
        checkOutput("f_if_ready", {31'h0, if_ready}, 32'h1);
        checkOutput("f_if_err", {31'h0, if_err}, 32'h0);
        checkOutput("f_if_rdata", if_rdata, 32'h2010_FFFF);
        checkOutput("f_dm_ready", {31'h0, dm_ready}, 32'h0);
        setMem(1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        checkOutput("f_pulse_end", {31'h0, if_ready}, 32'h0);
        checkOutput("f_idle_req", {31'h0, mem_req}, 32'h0);

        // Store with ack delayed three cycles.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
        for (int c = 0; c < 4; c++) begin
            step();
            checkOutput("s_mem_req", {31'h0, mem_req}, 32'h1);
            checkOutput("s_mem_we", {31'h0, mem_we}, 32'h1);
            checkOutput("s_mem_addr", mem_addr, 32'h100);
            checkOutput("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            checkOutput("s_dm_ready_early", {31'h0, dm_ready}, 32'h0);
            if (c == 3) setMem(1'b1, 32'h5555_5555);
        end
        step();
        checkOutput("s_dm_ready", {31'h0, dm_ready}, 32'h1);
        checkOutput("s_dm_err", {31'h0, dm_err}, 32'h0);
        checkOutput("s_dm_rdata_hold", dm_rdata, 32'h1111_2222);
        checkOutput("s_mem_req_drop", {31'h0, mem_req}, 32'h0);
        setMem(1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        checkOutput("s_pulse_end", {31'h0, dm_ready}, 32'h0);

        // Misaligned load answers next cycle with an error and no memory access.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h102, 32'h0);
        checkOutput("m_n_mem_req", {31'h0, mem_req}, 32'h0);
        step();
        checkOutput("m_dm_ready", {31'h0, dm_ready}, 32'h1);
        checkOutput("m_dm_err", {31'h0, dm_err}, 32'h1);
        checkOutput("m_mem_req", {31'h0, mem_req}, 32'h0);
        checkOutput("m_if_ready", {31'h0, if_ready}, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        checkOutput("m_pulse_end", {30'h0, dm_ready, dm_err}, 32'h0);
        checkOutput("m_mem_req_after", {31'h0, mem_req}, 32'h0);

        // Reset during BUSY abandons the fetch; a late ack must be ignored.
        applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        checkOutput("r_busy_req", {31'h0, mem_req}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("r_mem_req_drop", {31'h0, mem_req}, 32'h0);
        checkOutput("r_mem_addr", mem_addr, 32'h0);
        checkOutput("r_if_rdata", if_rdata, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        rst_n = 1'b1;
        setMem(1'b1, 32'h9999_9999);
        step();
        checkOutput("r_no_if_ready", {31'h0, if_ready}, 32'h0);
        checkOutput("r_no_dm_ready", {31'h0, dm_ready}, 32'h0);
        checkOutput("r_late_ack_req", {31'h0, mem_req}, 32'h0);
        setMem(1'b0, 32'h0);
        step();
        checkOutput("r_still_idle", {30'h0, if_ready, mem_req}, 32'h0);
        checkOutput("r_rdata_kept", if_rdata, 32'h0);

        // Normal service after the abandoned transaction.
        applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        checkOutput("p_mem_addr", mem_addr, 32'h44);
        setMem(1'b1, 32'h1234_5678);
        step();
        checkOutput("p_if_ready", {31'h0, if_ready}, 32'h1);
        checkOutput("p_if_rdata", if_rdata, 32'h1234_5678);
        setMem(1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter
Interface
REQ-001 clk  in  1  rising-edge clock; sole clock domain.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 if_req  in  1  fetch read request; held with if_addr until if_ready.
REQ-004 if_addr  in  32  fetch byte address.
REQ-005 if_rdata  out  32  fetched word; valid when if_ready=1.
REQ-006 if_ready  out  1  one-cycle completion pulse to fetch.
REQ-007 if_err  out  1  misaligned fetch flag; valid with if_ready.
REQ-008 dm_req  in  1  data-stage request; held with dm_we/dm_addr/dm_wdata until dm_ready.
REQ-009 dm_we  in  1  1=write, 0=read.
REQ-010 dm_addr  in  32  data byte address.
REQ-011 dm_wdata  in  32  store data.
REQ-012 dm_rdata  out  32  load word; valid when dm_ready=1.
REQ-013 dm_ready  out  1  one-cycle completion pulse to data stage.
REQ-014 dm_err  out  1  misaligned data-access flag; valid with dm_ready.
REQ-015 mem_req  out  1  request to shared single-port memory; held until mem_ack.
REQ-016 mem_we  out  1  write enable to memory.
REQ-017 mem_addr  out  32  word-aligned address to memory.
REQ-018 mem_wdata  out  32  write data to memory.
REQ-019 mem_rdata  in  32  memory read data; valid in mem_ack cycle.
REQ-020 mem_ack  in  1  memory completion; any latency ≥0 cycles after mem_req rises.
Function
REQ-021 FSM states IDLE, BUSY, RESP; one transaction in flight at a time.
REQ-022 IDLE: no request -> stay; else pick owner, latch owner's address/we/wdata, -> BUSY.
REQ-023 IDLE with owner's addr[1:0]≠0 -> RESP directly, err=1, no mem_req, no memory write.
REQ-024 BUSY: mem_req=1, mem_we/mem_addr/mem_wdata driven from latched values, stable until mem_ack.
REQ-025 BUSY with mem_ack=1: capture mem_rdata into owner's rdata register, -> RESP.
REQ-026 RESP: owner's ready=1 for exactly one cycle, err per REQ-023 else 0, -> IDLE.
REQ-027 Non-owner ready/err remain 0; rdata registers hold last value between transactions.
REQ-028 Minimum latency: request seen in IDLE cycle N, mem_ack in N+1, ready in N+2; 3 cycles per transaction.
REQ-029 Misaligned latency: ready+err in cycle N+1.
REQ-030 Write completion: dm_ready pulses; dm_rdata unchanged.
REQ-031 Contention (both req in IDLE): policy per REQ-036/037; loser keeps waiting, served at next IDLE.
REQ-032 Requester dropping req while owned: ignored; transaction completes, ready still pulses.
REQ-033 if_req never causes a memory write (mem_we=0 for fetch grants).
Reset
REQ-034 rst_n low: immediately state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ready=if_err=dm_ready=dm_err=0, if_rdata=dm_rdata=0, last_grant=IF.
REQ-035 Reset mid-BUSY abandons transaction: no ready pulse after release; late mem_ack in IDLE ignored.
Configuration
REQ-036 ARB_ROUND_ROBIN_EN defined: on contention grant requester not granted last; last_grant updates on every grant, so first contention after reset goes to DM, next to IF.
REQ-037 ARB_ROUND_ROBIN_EN undefined: fixed priority, DM always wins contention; last_grant unused.
Structure
REQ-038 Package mem_arb_pkg: state enum (IDLE/BUSY/RESP), owner enum (OWN_IF/OWN_DM), word-address mask constant.
REQ-039 Sub-module arb_pick: combinational owner selection from if_req, dm_req, last_grant; contains the ARB_ROUND_ROBIN_EN switch.
Verification
REQ-040 Single fetch if_addr=0x40, mem_ack same cycle, mem_rdata=0x2010FFFF -> if_ready in cycle N+2, if_rdata=0x2010FFFF, dm_ready=0.
REQ-041 Store dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF, mem_ack delayed 3 cycles -> mem_req high 4 cycles, fields stable, dm_ready once.
REQ-042 Both req every cycle for 4 transactions -> RR: DM,IF,DM,IF; fixed: DM,DM,DM,DM with if_ready never high.
REQ-043 dm_addr=0x102 read -> dm_ready+dm_err in N+1, mem_req never high.
REQ-044 rst_n low during BUSY, mem_ack after release -> mem_req drops immediately, no ready pulse, next request served normally.
